// File: rtl/mem_access_unit.sv
// Memory access unit for the 16-bit multicycle core: owns PC/IR/load-data registers and
// runs fetch, load and store transactions over a handshaked bus with memory-map checks.
module mem_access_unit #(
    parameter int               WIDTH             = 16,
    parameter logic [WIDTH-1:0] INSTRUCTION_MEM   = 16'h0000,
    parameter logic [WIDTH-1:0] INTERRUPT_CONTROL = 16'h5FFF,
    parameter logic [WIDTH-1:0] DATA_STACK        = 16'h6FFE,
    parameter logic [WIDTH-1:0] IO_MEM            = 16'hCFFD,
    parameter int               TIMEOUT           = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fetch_req,
    input  logic             ld_req,
    input  logic             st_req,
    input  logic [WIDTH-1:0] addr_in,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pc_load,
    input  logic [WIDTH-1:0] pc_next,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [1:0]       fault_cause,
    output logic [WIDTH-1:0] fault_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             io_sel,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, FAULT} state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_FETCH   = 2'b01;
    localparam logic [1:0] CAUSE_STORE   = 2'b10;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

    localparam logic [1:0] OP_FETCH = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    // Reject memory maps whose regions overlap or are out of order at elaboration time.
    if (TIMEOUT < 1 || TIMEOUT > 255 || DATA_STACK <= INTERRUPT_CONTROL || DATA_STACK >= IO_MEM)
    begin : g_paramCheck
        $error("mem_access_unit: illegal TIMEOUT or memory map parameters");
    end

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_instr;
    logic [WIDTH-1:0] r_rdata;
    logic [WIDTH-1:0] r_faultAddr;
    logic [1:0]       r_faultCause;
    logic [WIDTH-1:0] r_memAddr;
    logic [WIDTH-1:0] r_memWdata;
    logic             r_we;
    logic [1:0]       r_op;
    logic [7:0]       r_waitCnt;
    logic             r_done;
    logic             r_fault;

    logic             w_accept;
    logic             w_rangeFault;
    logic             w_timeout;
    logic [WIDTH-1:0] w_fetchAddr;
    logic [WIDTH-1:0] w_reqAddr;
    logic [1:0]       w_reqOp;

    // A same-cycle pc_load redirects the fetch itself to the branch target.
    always_comb begin
        w_fetchAddr  = pc_load ? pc_next : r_pc;
        w_accept     = (r_state == IDLE) && (fetch_req || ld_req || st_req);
        w_reqAddr    = fetch_req ? w_fetchAddr : addr_in;
        w_reqOp      = fetch_req ? OP_FETCH : (ld_req ? OP_LOAD : OP_STORE);
        w_rangeFault = fetch_req ? (w_fetchAddr > INTERRUPT_CONTROL)
                                 : (!ld_req && st_req && (addr_in <= INTERRUPT_CONTROL));
        w_timeout    = (r_state == BUS) && !mem_ready && (r_waitCnt == TIMEOUT_CNT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = w_rangeFault ? FAULT : BUS;
            BUS:     if (mem_ready) w_nextState = IDLE;
                     else if (w_timeout) w_nextState = FAULT;
            FAULT:   w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc         <= INSTRUCTION_MEM;
            r_instr      <= '0;
            r_rdata      <= '0;
            r_faultAddr  <= '0;
            r_faultCause <= CAUSE_NONE;
            r_memAddr    <= '0;
            r_memWdata   <= '0;
            r_we         <= 1'b0;
            r_op         <= OP_FETCH;
            r_waitCnt    <= '0;
            r_done       <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (pc_load && !fetch_req) begin
                        r_pc <= pc_next;
                    end
                    if (w_accept) begin
                        if (w_rangeFault) begin
                            r_faultCause <= fetch_req ? CAUSE_FETCH : CAUSE_STORE;
                            r_faultAddr  <= w_reqAddr;
                        end else begin
                            r_faultCause <= CAUSE_NONE;
                            r_memAddr    <= w_reqAddr;
                            r_memWdata   <= wdata;
                            r_we         <= (w_reqOp == OP_STORE);
                            r_op         <= w_reqOp;
                            r_waitCnt    <= '0;
                        end
                    end
                end
                BUS: begin
                    if (mem_ready) begin
                        r_done <= 1'b1;
                        if (r_op == OP_FETCH) begin
                            r_instr <= mem_rdata;
                            r_pc    <= r_memAddr + WIDTH'(1);
                        end else if (r_op == OP_LOAD) begin
                            r_rdata <= mem_rdata;
                        end
                    end else if (w_timeout) begin
                        r_faultCause <= CAUSE_TIMEOUT;
                        r_faultAddr  <= r_memAddr;
                    end else begin
                        r_waitCnt <= r_waitCnt + 8'd1;
                    end
                end
                FAULT: begin
                    r_done  <= 1'b1;
                    r_fault <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign fault       = r_fault;
    assign fault_cause = r_faultCause;
    assign fault_addr  = r_faultAddr;
    assign pc          = r_pc;
    assign instr       = r_instr;
    assign rdata       = r_rdata;
    assign mem_req     = (r_state == BUS);
    assign mem_we      = (r_state == BUS) && r_we;
    assign io_sel      = (r_state == BUS) && (r_memAddr >= IO_MEM);
    assign mem_addr    = r_memAddr;
    assign mem_wdata   = r_memWdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed transactions push expected results,
// a monitor pops and compares them on every done pulse.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_req = 1'b0, ld_req = 1'b0, st_req = 1'b0, pc_load = 1'b0;
    logic [15:0] addr_in = '0, wdata = '0, pc_next = '0;
    logic        busy, done, fault;
    logic [1:0]  fault_cause;
    logic [15:0] fault_addr, pc, instr, rdata;
    logic        mem_req, mem_we, io_sel;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_rdata = '0;

    typedef struct {
        logic        isFault;
        logic [1:0]  cause;
        logic [15:0] faultAddr;
        logic [15:0] pcVal;
        logic [15:0] instrVal;
        logic [15:0] rdataVal;
    } exp_t;

    exp_t sb[$];
    int   nCompared = 0;
    int   nMismatched = 0;
    int   memWaits = 0;
    logic [15:0] memData = '0;

    mem_access_unit dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .ld_req(ld_req), .st_req(st_req),
        .addr_in(addr_in), .wdata(wdata), .pc_load(pc_load), .pc_next(pc_next),
        .busy(busy), .done(done), .fault(fault), .fault_cause(fault_cause),
        .fault_addr(fault_addr), .pc(pc), .instr(instr), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .io_sel(io_sel), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Memory model: raise ready after memWaits low cycles; negative means never respond.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            if (reset && mem_req) begin
                mem_ready = (memWaits >= 0) && (cnt >= memWaits);
                mem_rdata = memData;
                cnt++;
            end else begin
                mem_ready = 1'b0;
                cnt = 0;
            end
        end
    end

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (reset && done) begin
            if (sb.size() == 0) begin
                checkOutput("unexpectedDone", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("fault", 32'(fault), 32'(e.isFault));
                checkOutput("faultCause", 32'(fault_cause), 32'(e.cause));
                checkOutput("faultAddr", 32'(fault_addr), 32'(e.faultAddr));
                checkOutput("pc", 32'(pc), 32'(e.pcVal));
                checkOutput("instr", 32'(instr), 32'(e.instrVal));
                checkOutput("rdata", 32'(rdata), 32'(e.rdataVal));
            end
        end
    end

    // Issues one request and returns its latency (request edge = cycle 1) plus bus observations.
    task automatic applyStimulus(input logic f, input logic l, input logic s, input logic pl,
                                 input logic [15:0] pn, input logic [15:0] addr, input logic [15:0] wd,
                                 input int waits, input logic [15:0] data,
                                 output int lat, output logic sawReq, output logic sawWe,
                                 output logic sawIo, output logic [15:0] seenAddr,
                                 output logic [15:0] seenWdata);
        memWaits = waits;
        memData  = data;
        sawReq = 1'b0; sawWe = 1'b0; sawIo = 1'b0; seenAddr = '0; seenWdata = '0;
        @(negedge clk);
        fetch_req = f; ld_req = l; st_req = s; pc_load = pl; pc_next = pn;
        addr_in = addr; wdata = wd;
        @(posedge clk);
        #1;
        fetch_req = 1'b0; ld_req = 1'b0; st_req = 1'b0; pc_load = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            if (mem_req) begin
                sawReq = 1'b1;
                seenAddr = mem_addr;
                seenWdata = mem_wdata;
                if (mem_we) sawWe = 1'b1;
                if (io_sel) sawIo = 1'b1;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) checkOutput("doneTimeout", 32'(lat), 32'd0);
    endtask

    initial begin
        int lat;
        logic sawReq, sawWe, sawIo;
        logic [15:0] seenAddr, seenWdata;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetMemReq", 32'(mem_req), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("resetPc", 32'(pc), 32'h0000);
        checkOutput("resetInstr", 32'(instr), 32'h0000);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetCause", 32'(fault_cause), 32'd0);
        checkOutput("resetMemAddr", 32'(mem_addr), 32'h0000);

        // Reset then zero-wait fetch
        sb.push_back('{1'b0, 2'b00, 16'h0000, 16'h0001, 16'hA5C3, 16'h0000});
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'hA5C3, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("fetchLatency", 32'(lat), 32'd2);
        checkOutput("fetchMemAddr", 32'(seenAddr), 32'h0000);
        checkOutput("fetchNoWe", 32'(sawWe), 32'd0);

        // Branch to the last instruction word with 3 wait states
        sb.push_back('{1'b0, 2'b00, 16'h0000, 16'h6000, 16'h1111, 16'h0000});
        applyStimulus(1, 0, 0, 1, 16'h5FFF, 16'h0, 16'h0, 3, 16'h1111, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("branchLatency", 32'(lat), 32'd5);
        checkOutput("branchMemAddr", 32'(seenAddr), 32'h5FFF);

        // Fetch past the instruction region
        sb.push_back('{1'b1, 2'b01, 16'h6000, 16'h6000, 16'h1111, 16'h0000});
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h0, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("fetchFaultLatency", 32'(lat), 32'd2);
        checkOutput("fetchFaultNoReq", 32'(sawReq), 32'd0);

        // Store to protected boundary
        sb.push_back('{1'b1, 2'b10, 16'h5FFF, 16'h6000, 16'h1111, 16'h0000});
        applyStimulus(0, 0, 1, 0, 16'h0, 16'h5FFF, 16'hAAAA, 0, 16'h0, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("storeFaultLatency", 32'(lat), 32'd2);
        checkOutput("storeFaultNoReq", 32'(sawReq), 32'd0);

        // Store to first I/O address; cause clears, fault address retained
        sb.push_back('{1'b0, 2'b00, 16'h5FFF, 16'h6000, 16'h1111, 16'h0000});
        applyStimulus(0, 0, 1, 0, 16'h0, 16'hCFFD, 16'h1234, 0, 16'h0, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("ioStoreWe", 32'(sawWe), 32'd1);
        checkOutput("ioStoreSel", 32'(sawIo), 32'd1);
        checkOutput("ioStoreWdata", 32'(seenWdata), 32'h1234);
        checkOutput("ioStoreAddr", 32'(seenAddr), 32'hCFFD);

        // Load from top of data stack
        sb.push_back('{1'b0, 2'b00, 16'h5FFF, 16'h6000, 16'h1111, 16'hBEEF});
        applyStimulus(0, 1, 0, 0, 16'h0, 16'h6FFE, 16'h0, 0, 16'hBEEF, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("loadIoSel", 32'(sawIo), 32'd0);

        // Load and store together: only the load runs
        sb.push_back('{1'b0, 2'b00, 16'h5FFF, 16'h6000, 16'h1111, 16'h4321});
        applyStimulus(0, 1, 1, 0, 16'h0, 16'h7000, 16'h9999, 0, 16'h4321, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("priorityNoWe", 32'(sawWe), 32'd0);

        // Bus timeout on a load
        sb.push_back('{1'b1, 2'b11, 16'h8000, 16'h6000, 16'h1111, 16'h4321});
        applyStimulus(0, 1, 0, 0, 16'h0, 16'h8000, 16'h0, -1, 16'hDEAD, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("timeoutLatency", 32'(lat), 32'd18);
        @(posedge clk);
        #1;
        checkOutput("timeoutBusyLow", 32'(busy), 32'd0);

        // Standalone PC load, then a 1-wait fetch from it
        @(negedge clk);
        pc_load = 1'b1; pc_next = 16'h0100;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
        checkOutput("pcLoadOnly", 32'(pc), 32'h0100);
        sb.push_back('{1'b0, 2'b00, 16'h8000, 16'h0101, 16'h2222, 16'h4321});
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 1, 16'h2222, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("waitFetchLatency", 32'(lat), 32'd3);
        checkOutput("waitFetchAddr", 32'(seenAddr), 32'h0100);

        // Reset in wait cycle 2 of a stalled fetch
        memWaits = -1;
        @(negedge clk);
        fetch_req = 1'b1;
        @(posedge clk);
        #1;
        fetch_req = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("midResetMemReq", 32'(mem_req), 32'd0);
        checkOutput("midResetPc", 32'(pc), 32'h0000);
        checkOutput("midResetBusy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("postResetIdle", 32'(busy), 32'd0);

        sb.push_back('{1'b0, 2'b00, 16'h0000, 16'h0001, 16'h7777, 16'h0000});
        applyStimulus(1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0, 16'h7777, lat, sawReq, sawWe, sawIo, seenAddr, seenWdata);
        checkOutput("postResetLatency", 32'(lat), 32'd2);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardDrained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
